// File: rtl/m_axis_rc_poison_filter.sv
// m_axis_rc_poison_filter
// Sits between the RC adapter and the LitePCIe RC consumer. Every beat goes
// through a two-entry skid buffer (output register plus skid register).
// s_axis_rc_tready is registered and only reflects skid occupancy, so there
// is no combinational path from m_axis_rc_tready.
// Optional feature: define M_AXIS_RC_POISON_DROP_EN to drop packets whose
// first beat carries tuser[1] (poisoned). drop_count saturates at 16'hFFFF.
// Without the macro every packet is forwarded, and drop_count/drop_pulse
// are held at 0.
module m_axis_rc_poison_filter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rc_tkeep,
  input  logic                  s_axis_rc_tlast,
  input  logic [84:0]           s_axis_rc_tuser,
  input  logic                  s_axis_rc_tvalid,
  output logic [3:0]            s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep,
  output logic                  m_axis_rc_tlast,
  output logic [84:0]           m_axis_rc_tuser,
  output logic                  m_axis_rc_tvalid,
  input  logic                  m_axis_rc_tready,
  output logic [15:0]           drop_count,
  output logic                  drop_pulse
);

  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic [KEEP_WIDTH-1:0] out_keep, skid_keep;
  logic                  out_last, skid_last;
  logic [84:0]           out_user, skid_user;
  logic                  out_valid, skid_valid, skid_valid_next;
  logic                  rdy_q;

  logic accept;     // beat handshake on the slave side
  logic drop_beat;  // current input beat is to be discarded
  logic push;       // accepted beat enters the buffer
  logic out_load;   // output register is free to take a new beat
  logic skid_load;  // accepted beat lands in the skid register

  assign accept    = s_axis_rc_tvalid & rdy_q;
  assign push      = accept & ~drop_beat;
  assign out_load  = ~out_valid | m_axis_rc_tready;
  // The skid entry is older than any new beat, so when both exist the skid
  // entry moves to the output and the new beat takes its place.
  assign skid_load = push & (out_load ? skid_valid : 1'b1);

  // Skid occupancy after this cycle; also drives the registered ready.
  always_comb begin
    skid_valid_next = skid_valid;
    if (out_load) begin
      if (skid_valid) skid_valid_next = push;
    end else if (push) begin
      skid_valid_next = 1'b1;
    end
  end

  // Valid flags, registered ready and payload registers of the skid buffer.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      rdy_q      <= ~skid_valid_next;
      if (out_load) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_keep  <= skid_keep;
          out_last  <= skid_last;
          out_user  <= skid_user;
        end else begin
          out_valid <= push;
          if (push) begin
            out_data <= s_axis_rc_tdata;
            out_keep <= s_axis_rc_tkeep;
            out_last <= s_axis_rc_tlast;
            out_user <= s_axis_rc_tuser;
          end
        end
      end
      if (skid_load) begin
        skid_data <= s_axis_rc_tdata;
        skid_keep <= s_axis_rc_tkeep;
        skid_last <= s_axis_rc_tlast;
        skid_user <= s_axis_rc_tuser;
      end
    end
  end

  assign s_axis_rc_tready = {4{rdy_q}};
  assign m_axis_rc_tdata  = out_data;
  assign m_axis_rc_tkeep  = out_keep;
  assign m_axis_rc_tlast  = out_last;
  assign m_axis_rc_tuser  = out_user;
  assign m_axis_rc_tvalid = out_valid;

`ifdef M_AXIS_RC_POISON_DROP_EN
  typedef enum logic [1:0] {SOP, BODY, DROP} state_t;

  state_t      state, state_next;
  logic        drop_start;
  logic [15:0] drop_cnt_q;
  logic        drop_pulse_q;

  // Packet framing: poison is only examined on the first beat of a packet.
  always_comb begin
    state_next = state;
    drop_beat  = 1'b0;
    drop_start = 1'b0;
    case (state)
      SOP: begin
        if (s_axis_rc_tuser[1]) begin
          drop_beat  = 1'b1;
          drop_start = accept;
        end
        if (accept && !s_axis_rc_tlast)
          state_next = s_axis_rc_tuser[1] ? DROP : BODY;
      end
      BODY: begin
        if (accept && s_axis_rc_tlast) state_next = SOP;
      end
      DROP: begin
        drop_beat = 1'b1;
        if (accept && s_axis_rc_tlast) state_next = SOP;
      end
      default: state_next = SOP;
    endcase
  end

  // State register plus saturating drop counter and one-cycle drop pulse.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state        <= SOP;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state        <= state_next;
      drop_pulse_q <= drop_start;
      if (drop_start && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;
`else
  assign drop_beat  = 1'b0;
  assign drop_count = '0;
  assign drop_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_m_axis_rc_poison_filter.sv
// Directed bench for m_axis_rc_poison_filter (32-bit data build).
// Expectations follow whether M_AXIS_RC_POISON_DROP_EN is defined.
module tb_m_axis_rc_poison_filter;

  logic        clk = 1'b0;
  logic        user_reset;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic [84:0] s_tuser;
  logic        s_tvalid;
  logic [3:0]  s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [84:0] m_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] drop_count;
  logic        drop_pulse;

  int checks = 0;
  int errors = 0;
  logic [63:0] got[$];
  int pulses = 0;
  int base;
  int p0;

  m_axis_rc_poison_filter #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) dut (
    .user_clk(clk),
    .user_reset(user_reset),
    .s_axis_rc_tdata(s_tdata),
    .s_axis_rc_tkeep(s_tkeep),
    .s_axis_rc_tlast(s_tlast),
    .s_axis_rc_tuser(s_tuser),
    .s_axis_rc_tvalid(s_tvalid),
    .s_axis_rc_tready(s_tready),
    .m_axis_rc_tdata(m_tdata),
    .m_axis_rc_tkeep(m_tkeep),
    .m_axis_rc_tlast(m_tlast),
    .m_axis_rc_tuser(m_tuser),
    .m_axis_rc_tvalid(m_tvalid),
    .m_axis_rc_tready(m_tready),
    .drop_count(drop_count),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  // Record every output handshake and count drop pulses.
  always @(posedge clk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1)
      got.push_back({24'b0, (m_tuser[84:2] == {51'b0, m_tdata}), m_tdata, m_tkeep, m_tlast, m_tuser[1:0]});
    if (drop_pulse === 1'b1) pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] exp_rec(input logic [31:0] d, input logic l, input logic [1:0] u);
    return {24'b0, 1'b1, d, d[7:4], l, u};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [31:0] d, input logic l, input logic [1:0] u);
    if (idx < got.size()) chk(tag, got[idx], exp_rec(d, l, u));
  endtask

  // Present one beat at a negedge and return at the negedge after its accept.
  task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] u);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = d[7:4];
    s_tlast  = l;
    s_tuser  = {51'b0, d, u};
    while (s_tready[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", {63'b0, s_tready[0]}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    user_reset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 1'b0;
    s_tuser = '0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", s_tready, 64'h0);
    chk("rst_tvalid", m_tvalid, 64'h0);
    chk("rst_count", drop_count, 64'h0);
    chk("rst_pulse", drop_pulse, 64'h0);
    user_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", s_tready, 64'hF);

    // Clean 3-beat packet, one-cycle latency
    base = got.size();
    chk("t1_pre_valid", m_tvalid, 64'h0);
    beat(32'h1111_00A0, 1'b0, 2'b00);
    chk("t1_lat_valid", m_tvalid, 64'h1);
    chk("t1_lat_data", m_tdata, 64'h1111_00A0);
    beat(32'h2222_00B0, 1'b0, 2'b00);
    beat(32'h3333_00C0, 1'b1, 2'b00);
    idle(3);
    chk("t1_n", got.size() - base, 64'd3);
    chk_out("t1_b0", base + 0, 32'h1111_00A0, 1'b0, 2'b00);
    chk_out("t1_b1", base + 1, 32'h2222_00B0, 1'b0, 2'b00);
    chk_out("t1_b2", base + 2, 32'h3333_00C0, 1'b1, 2'b00);
    chk("t1_count", drop_count, 64'h0);

    // Poisoned 2-beat packet followed by a clean 1-beat packet
    base = got.size();
    p0 = pulses;
    beat(32'h4444_0010, 1'b0, 2'b10);
    beat(32'h5555_0020, 1'b1, 2'b00);
    beat(32'h6666_0030, 1'b1, 2'b00);
    idle(3);
`ifdef M_AXIS_RC_POISON_DROP_EN
    chk("t2_n", got.size() - base, 64'd1);
    chk_out("t2_c", base + 0, 32'h6666_0030, 1'b1, 2'b00);
    chk("t2_pulses", pulses - p0, 64'd1);
    chk("t2_count", drop_count, 64'h1);
`else
    chk("t2_n", got.size() - base, 64'd3);
    chk_out("t2_p0", base + 0, 32'h4444_0010, 1'b0, 2'b10);
    chk_out("t2_p1", base + 1, 32'h5555_0020, 1'b1, 2'b00);
    chk_out("t2_c", base + 2, 32'h6666_0030, 1'b1, 2'b00);
    chk("t2_pulses", pulses - p0, 64'd0);
    chk("t2_count", drop_count, 64'h0);
`endif

    // Poison on a mid-packet beat does not start a drop
    base = got.size();
    beat(32'h7777_0040, 1'b0, 2'b00);
    beat(32'h8888_0050, 1'b1, 2'b10);
    idle(3);
    chk("t3_n", got.size() - base, 64'd2);
    chk_out("t3_b0", base + 0, 32'h7777_0040, 1'b0, 2'b00);
    chk_out("t3_b1", base + 1, 32'h8888_0050, 1'b1, 2'b10);

    // Discontinue is forwarded and leaves framing untouched
    base = got.size();
    beat(32'h9999_0060, 1'b1, 2'b01);
    beat(32'hAAAA_0070, 1'b1, 2'b11);
    beat(32'hBBBB_0080, 1'b1, 2'b00);
    idle(3);
`ifdef M_AXIS_RC_POISON_DROP_EN
    chk("t4_n", got.size() - base, 64'd2);
    chk_out("t4_d", base + 0, 32'h9999_0060, 1'b1, 2'b01);
    chk_out("t4_e", base + 1, 32'hBBBB_0080, 1'b1, 2'b00);
    chk("t4_count", drop_count, 64'h2);
`else
    chk("t4_n", got.size() - base, 64'd3);
    chk_out("t4_d", base + 0, 32'h9999_0060, 1'b1, 2'b01);
    chk_out("t4_q", base + 1, 32'hAAAA_0070, 1'b1, 2'b11);
    chk_out("t4_e", base + 2, 32'hBBBB_0080, 1'b1, 2'b00);
    chk("t4_count", drop_count, 64'h0);
`endif

    // Backpressure: two beats accepted while the consumer stalls
    m_tready = 1'b0;
    base = got.size();
    beat(32'hCCCC_0090, 1'b0, 2'b00);
    beat(32'hDDDD_00E0, 1'b1, 2'b00);
    chk("t5_tready_full", s_tready, 64'h0);
    chk("t5_hold_valid", m_tvalid, 64'h1);
    chk("t5_hold_data", m_tdata, 64'hCCCC_0090);
    idle(2);
    chk("t5_stable_data", m_tdata, 64'hCCCC_0090);
    chk("t5_stable_last", m_tlast, 64'h0);
    chk("t5_none_out", got.size() - base, 64'd0);
    m_tready = 1'b1;
    idle(3);
    chk("t5_n", got.size() - base, 64'd2);
    chk_out("t5_a", base + 0, 32'hCCCC_0090, 1'b0, 2'b00);
    chk_out("t5_b", base + 1, 32'hDDDD_00E0, 1'b1, 2'b00);
    chk("t5_tready_back", s_tready, 64'hF);

`ifdef M_AXIS_RC_POISON_DROP_EN
    // Saturation of the drop counter
    force dut.drop_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.drop_cnt_q;
    chk("t6_forced", drop_count, 64'hFFFE);
    base = got.size();
    p0 = pulses;
    beat(32'h0101_0010, 1'b1, 2'b10);
    chk("t6_first", drop_count, 64'hFFFF);
    beat(32'h0202_0020, 1'b1, 2'b10);
    beat(32'h0303_0030, 1'b1, 2'b10);
    idle(2);
    chk("t6_sat", drop_count, 64'hFFFF);
    chk("t6_pulses", pulses - p0, 64'd3);
    chk("t6_n", got.size() - base, 64'd0);
`endif

    // Reset in the middle of a (dropped) packet with a buffered beat
    m_tready = 1'b0;
    base = got.size();
    beat(32'hEEEE_00F0, 1'b1, 2'b00);
    beat(32'h1234_0050, 1'b0, 2'b10);
    s_tvalid = 1'b0;
    user_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_tready", s_tready, 64'h0);
    chk("t7_rst_tvalid", m_tvalid, 64'h0);
    chk("t7_rst_count", drop_count, 64'h0);
    user_reset = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("t7_post_tready", s_tready, 64'hF);
    beat(32'h5678_0060, 1'b0, 2'b00);
    beat(32'h9ABC_0070, 1'b1, 2'b00);
    idle(3);
    chk("t7_n", got.size() - base, 64'd2);
    chk_out("t7_y1", base + 0, 32'h5678_0060, 1'b0, 2'b00);
    chk_out("t7_y2", base + 1, 32'h9ABC_0070, 1'b1, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
